grad_hist: RTL and testbench

GRAD_HIST -- requirements
Module: grad_hist

---
 rtl/grad_hist_pkg.sv | 38 +++
 rtl/grad_dir_quant.sv | 41 ++++
 rtl/grad_hist.sv | 153 +++++++++++++++
 tb/tb_grad_hist.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/grad_hist_pkg.sv
// Shared constants, FSM encoding and stage-1 record for the gradient-direction
// histogram block.
package grad_hist_pkg;

  localparam int NUM_BINS  = 8;
  localparam int BIN_W     = 3;
  localparam int GRAD_W    = 11;
  localparam int AMP_W     = 12;
  localparam int DRAIN_LEN = 2;
  localparam int SCAN_LEN  = 8;

  typedef logic [BIN_W-1:0] bin_t;

  // Direction bins, counter-clockwise from horizontal in 22.5 degree steps.
  localparam bin_t BIN_0 = 3'd0;
  localparam bin_t BIN_1 = 3'd1;
  localparam bin_t BIN_2 = 3'd2;
  localparam bin_t BIN_3 = 3'd3;
  localparam bin_t BIN_4 = 3'd4;
  localparam bin_t BIN_5 = 3'd5;
  localparam bin_t BIN_6 = 3'd6;
  localparam bin_t BIN_7 = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC,
    ST_DRAIN,
    ST_SCAN,
    ST_DONE
  } state_t;

  typedef struct packed {
    bin_t             bin;
    logic [AMP_W-1:0] amp;
    logic             zero;
  } s1_t;

endpackage

// File: rtl/grad_dir_quant.sv
// Combinational gradient classifier: magnitude |gx|+|gy| and one of eight
// direction bins. The caller registers the result.
module grad_dir_quant
  import grad_hist_pkg::*;
(
  input  logic signed [GRAD_W-1:0] gx,
  input  logic signed [GRAD_W-1:0] gy,
  output s1_t                      q
);

  logic [GRAD_W-1:0] ax;
  logic [GRAD_W-1:0] ay;
  logic [13:0]       ax_w;
  logic [13:0]       ay_w;
  logic              same_sign;

  // NOTE: every signal written in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    ax        = gx[GRAD_W-1] ? $unsigned(-gx) : $unsigned(gx);
    ay        = gy[GRAD_W-1] ? $unsigned(-gy) : $unsigned(gy);
    ax_w      = 14'(ax);
    ay_w      = 14'(ay);
    same_sign = (gx[GRAD_W-1] == gy[GRAD_W-1]);

    q.amp  = AMP_W'(ax) + AMP_W'(ay);
    q.zero = (ax == '0) && (ay == '0);
    q.bin  = BIN_4;

    // Tangent thresholds 0.2, 0.667, 1.5 and 5 without a divider.
    if (14'd5 * ay_w < ax_w)
      q.bin = BIN_0;
    else if (14'd3 * ay_w < 14'd2 * ax_w)
      q.bin = same_sign ? BIN_1 : BIN_7;
    else if (14'd2 * ay_w < 14'd3 * ax_w)
      q.bin = same_sign ? BIN_2 : BIN_6;
    else if (ay_w < 14'd5 * ax_w)
      q.bin = same_sign ? BIN_3 : BIN_5;
  end

endmodule

// File: rtl/grad_hist.sv
// Block-wise gradient-direction histogram with winner-take-all scan.
// Optional flatness flag is built only when GRAD_HIST_FLAT_EN is defined.
module grad_hist
  import grad_hist_pkg::*;
#(
  parameter int BLK_SAMPLES = 64,
  parameter int ACC_W       = 18,
  parameter int FLAT_THR    = 256
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     gxgyrun,
  input  logic signed [GRAD_W-1:0] gx,
  input  logic signed [GRAD_W-1:0] gy,
  input  logic                     clr,
  output logic                     in_ready,
  output logic                     drop,
  output logic                     done,
  output logic [BIN_W-1:0]         best_bin,
  output logic [ACC_W-1:0]         best_acc,
  output logic                     flat
);

  localparam int               CNT_W    = $clog2(BLK_SAMPLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLK_SAMPLES - 1);

  state_t            state_q;
  state_t            state_d;
  logic [2:0]        phase_q;
  logic [CNT_W-1:0]  cnt_q;
  s1_t               s1_d;
  s1_t               s1_q;
  logic              s1_vld_q;
  logic [ACC_W-1:0]  acc_q [NUM_BINS];
  bin_t              run_bin_q;
  logic [ACC_W-1:0]  run_acc_q;
  bin_t              scan_idx;
  logic              scan_gt;
  bin_t              fin_bin;
  logic [ACC_W-1:0]  fin_acc;
  logic              accept;
  logic              last_sample;
  logic              scan_last;

  grad_dir_quant u_quant (
    .gx (gx),
    .gy (gy),
    .q  (s1_d)
  );

  // Gating with rstn keeps every output low while reset is held.
  assign in_ready    = rstn && (state_q == ST_IDLE || state_q == ST_ACC);
  assign drop        = rstn && gxgyrun && !in_ready;
  assign done        = (state_q == ST_DONE);
  assign accept      = gxgyrun && in_ready && !clr;
  assign last_sample = accept && (cnt_q == LAST_CNT);
  assign scan_last   = (state_q == ST_SCAN) && (phase_q == 3'(SCAN_LEN - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = last_sample ? ST_DRAIN : ST_ACC;
      ST_ACC:   if (last_sample) state_d = ST_DRAIN;
      ST_DRAIN: if (phase_q == 3'(DRAIN_LEN - 1)) state_d = ST_SCAN;
      ST_SCAN:  if (phase_q == 3'(SCAN_LEN - 1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (clr) state_d = ST_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= (state_d != state_q) ? 3'd0 : phase_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      cnt_q <= '0;
    else if (clr || state_q == ST_DONE)
      cnt_q <= '0;
    else if (accept)
      cnt_q <= cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld_q <= 1'b0;
      s1_q     <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) s1_q <= s1_d;
    end
  end

  // NOTE: the bin accumulators are a small register file that must read zero
  // during reset, so each entry is reset explicitly rather than left to a RAM.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int b = 0; b < NUM_BINS; b++) acc_q[b] <= '0;
    end else if (clr || state_q == ST_DONE) begin
      for (int b = 0; b < NUM_BINS; b++) acc_q[b] <= '0;
    end else if (s1_vld_q && !s1_q.zero) begin
      acc_q[s1_q.bin] <= acc_q[s1_q.bin] + ACC_W'(s1_q.amp);
    end
  end

  // Strictly-greater compare keeps the lowest bin on ties.
  assign scan_idx = bin_t'(phase_q);
  assign scan_gt  = acc_q[scan_idx] > run_acc_q;
  assign fin_bin  = scan_gt ? scan_idx : run_bin_q;
  assign fin_acc  = scan_gt ? acc_q[scan_idx] : run_acc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_bin_q <= BIN_0;
      run_acc_q <= '0;
      best_bin  <= BIN_0;
      best_acc  <= '0;
    end else if (state_q == ST_DRAIN) begin
      run_bin_q <= BIN_0;
      run_acc_q <= '0;
    end else if (state_q == ST_SCAN && !clr) begin
      run_bin_q <= fin_bin;
      run_acc_q <= fin_acc;
      if (scan_last) begin
        best_bin <= fin_bin;
        best_acc <= fin_acc;
      end
    end
  end

`ifdef GRAD_HIST_FLAT_EN
  localparam logic [ACC_W-1:0] FLAT_LIM = ACC_W'(FLAT_THR);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      flat <= 1'b0;
    else if (scan_last && !clr)
      flat <= (fin_acc < FLAT_LIM);
  end
`else
  assign flat = 1'b0;
`endif

endmodule

// File: tb/tb_grad_hist.sv
// Self-checking bench for grad_hist: directed blocks plus randomized blocks
// compared against a behavioural histogram model.
module tb_grad_hist;

  localparam int BLK      = 64;
  localparam int ACC_W    = 18;
  localparam int FLAT_THR = 256;

  logic               clk     = 1'b0;
  logic               rstn    = 1'b0;
  logic               gxgyrun = 1'b0;
  logic               clr     = 1'b0;
  logic signed [10:0] gx      = '0;
  logic signed [10:0] gy      = '0;
  logic               in_ready;
  logic               drop;
  logic               done;
  logic [2:0]         best_bin;
  logic [ACC_W-1:0]   best_acc;
  logic               flat;

  int n_checks   = 0;
  int n_errors   = 0;
  int done_seen  = 0;
  int qx[$];
  int qy[$];
  int exp_bin    = 0;
  int exp_acc    = 0;
  int exp_flat   = 0;

  grad_hist #(
    .BLK_SAMPLES (BLK),
    .ACC_W       (ACC_W),
    .FLAT_THR    (FLAT_THR)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .gxgyrun  (gxgyrun),
    .gx       (gx),
    .gy       (gy),
    .clr      (clr),
    .in_ready (in_ready),
    .drop     (drop),
    .done     (done),
    .best_bin (best_bin),
    .best_acc (best_acc),
    .flat     (flat)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Direction rules written on signed integers straight from the tangent bands.
  function automatic int ref_bin(input int x, input int y);
    int ax = (x < 0) ? -x : x;
    int ay = (y < 0) ? -y : y;
    bit s  = ((x >= 0) == (y >= 0));
    if (5 * ay < ax)     return 0;
    if (3 * ay < 2 * ax) return s ? 1 : 7;
    if (2 * ay < 3 * ax) return s ? 2 : 6;
    if (ay < 5 * ax)     return s ? 3 : 5;
    return 4;
  endfunction

  task automatic model_block();
    int hist[8];
    foreach (hist[b]) hist[b] = 0;
    foreach (qx[i]) begin
      int a = ((qx[i] < 0) ? -qx[i] : qx[i]) + ((qy[i] < 0) ? -qy[i] : qy[i]);
      if (a != 0) hist[ref_bin(qx[i], qy[i])] += a;
    end
    exp_bin = 0;
    exp_acc = hist[0];
    for (int b = 1; b < 8; b++)
      if (hist[b] > exp_acc) begin
        exp_bin = b;
        exp_acc = hist[b];
      end
`ifdef GRAD_HIST_FLAT_EN
    exp_flat = (exp_acc < FLAT_THR) ? 1 : 0;
`else
    exp_flat = 0;
`endif
  endtask

  task automatic fill(input int n, input int x, input int y);
    repeat (n) begin
      qx.push_back(x);
      qy.push_back(y);
    end
  endtask

  task automatic fill_rand(input int n, input int lim);
    repeat (n) begin
      qx.push_back(int'($urandom_range(0, 2 * lim)) - lim);
      qy.push_back(int'($urandom_range(0, 2 * lim)) - lim);
    end
  endtask

  task automatic drive_samples(input string tag);
    for (int i = 0; i < qx.size(); i++) begin
      @(posedge clk); #1;
      gxgyrun = 1'b1;
      gx      = 11'(qx[i]);
      gy      = 11'(qy[i]);
      @(negedge clk);
      check({tag, " rdy_in"}, 32'(in_ready), 32'd1);
    end
  endtask

  // Drives the queued block and checks the exact 11-cycle drain/scan/done window.
  task automatic run_block(input string tag, input bit hold_run);
    model_block();
    drive_samples(tag);
    @(posedge clk); #1;
    gxgyrun = hold_run;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      check({tag, " rdy_lo"}, 32'(in_ready), 32'd0);
      check({tag, " done_t"}, 32'(done), 32'(k == 11));
      check({tag, " drop"}, 32'(drop), 32'(hold_run));
      if (k == 11) begin
        check({tag, " bin"}, 32'(best_bin), 32'(exp_bin));
        check({tag, " acc"}, 32'(best_acc), 32'(exp_acc));
        check({tag, " flat"}, 32'(flat), 32'(exp_flat));
      end
      @(posedge clk); #1;
      if (k == 11) gxgyrun = 1'b0;
    end
    @(negedge clk);
    check({tag, " rdy_back"}, 32'(in_ready), 32'd1);
    check({tag, " done_lo"}, 32'(done), 32'd0);
    check({tag, " bin_hold"}, 32'(best_bin), 32'(exp_bin));
    check({tag, " acc_hold"}, 32'(best_acc), 32'(exp_acc));
    qx.delete();
    qy.delete();
  endtask

  initial begin
    int d0;

    // Reset state, with a sample offered to prove drop stays low.
    gxgyrun = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst drop", 32'(drop), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst bin", 32'(best_bin), 32'd0);
    check("rst acc", 32'(best_acc), 32'd0);
    check("rst flat", 32'(flat), 32'd0);
    gxgyrun = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("rel in_ready", 32'(in_ready), 32'd1);

    fill(BLK, 100, 0);
    run_block("horiz", 1'b0);

    fill(BLK, 50, 50);
    run_block("diag_pos", 1'b0);

    fill(BLK, 50, -50);
    run_block("diag_neg", 1'b0);

    fill(BLK / 2, 10, 0);
    fill(BLK / 2, 0, 10);
    run_block("tie", 1'b0);

    fill(BLK, 0, 0);
    run_block("zeros", 1'b0);

    fill(17, 0, 0);
    fill(1, -1024, 1023);
    fill(BLK - 18, 0, 0);
    run_block("extreme", 1'b0);

    fill_rand(BLK, 1024);
    run_block("drop_hold", 1'b1);

    // Abort a partial block with a colliding sample, then a full block.
    d0 = done_seen;
    fill(20, 100, 0);
    drive_samples("pre_clr");
    qx.delete();
    qy.delete();
    @(posedge clk); #1;
    clr = 1'b1;
    gx  = 11'sd100;
    gy  = 11'sd0;
    @(negedge clk);
    check("clr bin_hold", 32'(best_bin), 32'(exp_bin));
    check("clr acc_hold", 32'(best_acc), 32'(exp_acc));
    @(posedge clk); #1;
    clr     = 1'b0;
    gxgyrun = 1'b0;
    @(negedge clk);
    check("clr rdy_next", 32'(in_ready), 32'd1);
    check("clr no_done", 32'(done), 32'd0);
    fill(BLK, 0, 100);
    run_block("after_clr", 1'b0);
    @(posedge clk);
    check("clr one_done", 32'(done_seen - d0), 32'd1);

    // Abort in the middle of the scan: no done, previous result held.
    d0 = done_seen;
    fill_rand(BLK, 1024);
    drive_samples("pre_scan_clr");
    qx.delete();
    qy.delete();
    @(posedge clk); #1;
    gxgyrun = 1'b0;
    repeat (5) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    check("sclr rdy_next", 32'(in_ready), 32'd1);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("sclr no_done", 32'(done_seen - d0), 32'd0);
    check("sclr bin_hold", 32'(best_bin), 32'(exp_bin));
    check("sclr acc_hold", 32'(best_acc), 32'(exp_acc));
    fill_rand(BLK, 1024);
    run_block("after_sclr", 1'b0);

    // Reset asserted during the scan.
    fill_rand(BLK, 1024);
    drive_samples("pre_rst");
    qx.delete();
    qy.delete();
    @(posedge clk); #1;
    gxgyrun = 1'b0;
    repeat (5) @(posedge clk);
    #3 rstn = 1'b0;
    gxgyrun = 1'b1;
    #1;
    check("srst in_ready", 32'(in_ready), 32'd0);
    check("srst drop", 32'(drop), 32'd0);
    check("srst done", 32'(done), 32'd0);
    check("srst bin", 32'(best_bin), 32'd0);
    check("srst acc", 32'(best_acc), 32'd0);
    check("srst flat", 32'(flat), 32'd0);
    gxgyrun = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("srst rdy_back", 32'(in_ready), 32'd1);
    fill_rand(BLK, 1024);
    run_block("after_rst", 1'b0);

    for (int r = 0; r < 3; r++) begin
      fill_rand(BLK, 1024);
      run_block("rand_full", 1'b0);
      fill_rand(BLK, 3);
      run_block("rand_small", 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
